// File: rtl/mips_rtype_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_rtype_pkg
//  Description : Shared MIPS R-type encoding constants, ALU select codes and
//                instruction field positions. Used by the encoder, the ALU
//                control decoder and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_rtype_pkg;

    // All R-type instructions share the all-zero major opcode
    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

    // Function field values for the supported R-type operations
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;

    // ALU select codes; every 3-bit value is a legal operation
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SLL = 3'b011,
        ALU_SUB = 3'b100,
        ALU_SRL = 3'b101,
        ALU_XOR = 3'b110,
        ALU_NOR = 3'b111
    } alu_sel_t;

    // Least significant bit of each field inside the 32-bit instruction word
    localparam int OPCODE_LSB = 26;
    localparam int RS_LSB     = 21;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 11;
    localparam int SH_LSB     = 6;
    localparam int FUNCT_LSB  = 0;

    // Assemble an R-type word from already-resolved fields
    function automatic logic [31:0] pack_rtype(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [4:0] shamt,
        input logic [5:0] funct
    );
        logic [31:0] word;
        word = '0;
        word[OPCODE_LSB +: 6] = OPCODE_RTYPE;
        word[RS_LSB     +: 5] = rs;
        word[RT_LSB     +: 5] = rt;
        word[RD_LSB     +: 5] = rd;
        word[SH_LSB     +: 5] = shamt;
        word[FUNCT_LSB  +: 6] = funct;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtype_funct_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_funct_encoder
//  Description : Combinational map from ALU select code to the R-type funct
//                field, plus a flag marking the shift operations that carry
//                a meaningful shamt field.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtype_funct_encoder
    import mips_rtype_pkg::*;
(
    input  logic [2:0] i_sel,
    output logic [5:0] o_funct,
    output logic       o_is_shift
);

    // Full 8-way decode; no code is reserved so there is no error output
    always_comb begin
        o_funct    = FUNCT_AND;
        o_is_shift = 1'b0;
        case (alu_sel_t'(i_sel))
            ALU_AND: o_funct = FUNCT_AND;
            ALU_OR:  o_funct = FUNCT_OR;
            ALU_ADD: o_funct = FUNCT_ADD;
            ALU_SLL: begin
                o_funct    = FUNCT_SLL;
                o_is_shift = 1'b1;
            end
            ALU_SUB: o_funct = FUNCT_SUB;
            ALU_SRL: begin
                o_funct    = FUNCT_SRL;
                o_is_shift = 1'b1;
            end
            ALU_XOR: o_funct = FUNCT_XOR;
            ALU_NOR: o_funct = FUNCT_NOR;
            default: begin
                o_funct    = FUNCT_AND;
                o_is_shift = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rtype_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rtype_instr_encoder
//  Description : Buffered MIPS R-type instruction encoder. Encodes an ALU
//                select code plus register/shift fields into a 32-bit word at
//                the input handshake, queues finished words in a small FIFO
//                and streams them out over a second valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module rtype_instr_encoder
    import mips_rtype_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] issued_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_count_full = (PTR_W + 1)'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_issued_count;

    logic [5:0]  w_funct;
    logic        w_is_shift;
    logic [4:0]  w_shamt;
    logic [31:0] w_word;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_push;
    logic        w_pop;

    rtype_funct_encoder u_funct_enc (
        .i_sel      (in_sel),
        .o_funct    (w_funct),
        .o_is_shift (w_is_shift)
    );

    // Encode at the input so the FIFO only ever holds finished words
    always_comb begin
        w_shamt = w_is_shift ? in_shamt : 5'd0;
        w_word  = pack_rtype(in_rs, in_rt, in_rd, w_shamt, w_funct);
    end

    // Handshake qualifiers derive from the registered count only, so a pop
    // in the same cycle never opens room for a push into a full FIFO
    always_comb begin
        w_in_ready  = (r_count != c_count_full);
        w_out_valid = (r_count != '0);
        w_push      = in_valid && w_in_ready;
        w_pop       = w_out_valid && out_ready;
    end

    // Storage has no reset; stale entries are masked by the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Count completed output handshakes, wrapping at the counter width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_count <= '0;
        end else if (w_pop) begin
            r_issued_count <= r_issued_count + CNT_W'(1);
        end
    end

    // Output word is forced to zero while empty so reset is visible at once
    always_comb begin
        in_ready     = w_in_ready;
        out_valid    = w_out_valid;
        out_instr    = w_out_valid ? r_mem[r_rd_ptr] : 32'd0;
        issued_count = r_issued_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_rtype_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rtype_instr_encoder
//  Description : Self-checking bench for rtype_instr_encoder with a queue
//                scoreboard of expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rtype_instr_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sel;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [4:0]       in_rd;
    logic [4:0]       in_shamt;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic [CNT_W-1:0] issued_count;

    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  sel;
    } sb_t;

    sb_t sb[$];
    int  tests_run    = 0;
    int  tests_failed = 0;

    rtype_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_shamt     (in_shamt),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    // Reference encoding straight from the funct table
    function automatic logic [31:0] model_word(input logic [2:0] sel, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [4:0] sh);
        logic [5:0] f;
        case (sel)
            3'd0:    f = 6'h24;
            3'd1:    f = 6'h25;
            3'd2:    f = 6'h20;
            3'd3:    f = 6'h00;
            3'd4:    f = 6'h22;
            3'd5:    f = 6'h02;
            3'd6:    f = 6'h26;
            default: f = 6'h27;
        endcase
        return {6'b000000, rs, rt, rd, (sel == 3'd3 || sel == 3'd5) ? sh : 5'd0, f};
    endfunction

    // ALU control decode: funct back to select code
    function automatic logic [3:0] alu_ctrl_decode(input logic [5:0] funct);
        case (funct)
            6'h24:   return 4'd0;
            6'h25:   return 4'd1;
            6'h20:   return 4'd2;
            6'h00:   return 4'd3;
            6'h22:   return 4'd4;
            6'h02:   return 4'd5;
            6'h26:   return 4'd6;
            6'h27:   return 4'd7;
            default: return 4'hF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh);
        in_sel   = s;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_shamt = sh;
    endtask

    task automatic drive_random();
        drive(3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    endtask

    // One clock: sample handshakes at the falling edge (inputs are stable
    // then), update the scoreboard, and return just after the rising edge
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (rst_n) begin
            if (in_valid && in_ready) begin
                e.word = model_word(in_sel, in_rs, in_rt, in_rd, in_shamt);
                e.sel  = in_sel;
                sb.push_back(e);
            end
            if (out_valid && out_ready) begin
                check("pop_has_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_word", out_instr, e.word);
                    check("alu_decode_sel", {28'd0, alu_ctrl_decode(out_instr[5:0])}, {29'd0, e.sel});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] exp_f [8];
        int         pushes;
        int         guard;

        exp_f = '{6'h24, 6'h25, 6'h20, 6'h00, 6'h22, 6'h02, 6'h26, 6'h27};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(3'd0, 5'd0, 5'd0, 5'd0, 5'd0);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_issued", {16'd0, issued_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single add push: shamt must be zeroed
        drive(3'b010, 5'd1, 5'd2, 5'd3, 5'd7);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_word", out_instr, 32'h0022_1820);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("add_issued", {16'd0, issued_count}, 32'd1);
        check("add_drained", {31'd0, out_valid}, 32'd0);

        // Shift ops keep shamt
        drive(3'b011, 5'd0, 5'd4, 5'd5, 5'd3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("sll_word", out_instr, 32'h0004_28C0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        drive(3'b101, 5'd0, 5'd4, 5'd5, 5'd3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("srl_word", out_instr, 32'h0004_28C2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Sweep every select code with zero fields
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 5'd0, 5'd0, 5'd0, 5'd0);
            step();
            check("sweep_funct", {26'd0, out_instr[5:0]}, {26'd0, exp_f[i]});
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("sweep_issued", {16'd0, issued_count}, 32'd11);

        // Fill to full with the consumer stalled
        pushes   = 0;
        guard    = 0;
        in_valid = 1'b1;
        while (in_ready && guard < 10) begin
            drive_random();
            pushes++;
            guard++;
            step();
        end
        check("fill_count", pushes, DEPTH);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive(3'b111, 5'd31, 5'd31, 5'd31, 5'd31);
        step();
        drive(3'b000, 5'd9, 5'd9, 5'd9, 5'd9);
        step();
        check("full_held", {31'd0, in_ready}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("ready_after_pop", {31'd0, in_ready}, 32'd1);
        repeat (DEPTH) step();
        out_ready = 1'b0;
        check("full_drained", {31'd0, out_valid}, 32'd0);

        // Sustained streaming at one word per cycle
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive_random();
            step();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
        end

        // Keep streaming until the issued counter reaches its top value
        guard = 0;
        while (issued_count != 16'hFFFF && guard < 70000) begin
            drive_random();
            step();
            guard++;
        end
        check("issued_top", {16'd0, issued_count}, 32'h0000_FFFF);
        drive_random();
        step();
        check("issued_wrap", {16'd0, issued_count}, 32'd0);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset with two words queued
        in_valid = 1'b1;
        drive_random();
        step();
        drive_random();
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_in_ready", {31'd0, in_ready}, 32'd1);
        check("async_out_instr", out_instr, 32'd0);
        check("async_issued", {16'd0, issued_count}, 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("no_stale_word", {31'd0, out_valid}, 32'd0);
        end
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
